// File: rtl/carry_norm.sv
// carry_norm: turns a stream of wide convolution coefficients (LS first)
// into normalized radix-BASE digits (LS first) with no leading zeros.
//
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   coef_valid/ready - coefficient handshake; coef_data, coef_last
//   dig_valid/ready  - digit handshake; dig_data, dig_last
//   dig_count        - digits emitted for the current product
//   busy             - product in flight (first accept .. dig_last handshake)
module carry_norm #(
    parameter int WORD  = 16,
    parameter int DWORD = 32,
    parameter int BASE  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coef_valid,
    output logic             coef_ready,
    input  logic [DWORD-1:0] coef_data,
    input  logic             coef_last,
    output logic             dig_valid,
    input  logic             dig_ready,
    output logic [WORD-1:0]  dig_data,
    output logic             dig_last,
    output logic [WORD-1:0]  dig_count,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IN,
        S_EMITP,
        S_ZERO,
        S_FLUSH,
        S_FINAL
    } state_t;

    localparam logic [DWORD:0]  BASE_W = (DWORD+1)'(BASE);
    localparam logic [WORD-1:0] ONE    = {{(WORD-1){1'b0}}, 1'b1};

    state_t            state;
    logic [DWORD:0]    carry;
    logic [WORD-1:0]   p;
    logic              pv;
    logic [WORD-1:0]   n;
    logic [WORD-1:0]   zrun;
    logic              ended;

    logic              step_en;
    logic              dig_hs;
    logic [DWORD-1:0]  step_x;
    logic [DWORD:0]    acc;
    logic [DWORD:0]    carry_nxt;
    logic [WORD-1:0]   d_val;
    logic              ended_nxt;

    // Where to go once any pending output for the current step is done.
    function automatic state_t ret_state(input logic e, input logic c_nz);
        if (!e)
            return S_IN;
        else if (c_nz)
            return S_FLUSH;
        else
            return S_FINAL;
    endfunction

    // One digit step per cycle; S_FLUSH feeds zero to drain the carry.
    always_comb begin
        step_en   = (state == S_IN && coef_valid) || (state == S_FLUSH);
        step_x    = (state == S_IN) ? coef_data : '0;
        acc       = {1'b0, step_x} + carry;
        d_val     = WORD'(acc % BASE_W);
        carry_nxt = acc / BASE_W;
        ended_nxt = (state == S_IN) ? coef_last : ended;
    end

    // Outputs decode only registered state, so they hold during stalls.
    always_comb begin
        coef_ready = 1'b0;
        dig_valid  = 1'b0;
        dig_last   = 1'b0;
        dig_data   = '0;
        unique case (state)
            S_IN: begin
                coef_ready = 1'b1;
            end
            S_EMITP: begin
                dig_valid = 1'b1;
                dig_data  = p;
            end
            S_ZERO: begin
                dig_valid = 1'b1;
            end
            S_FINAL: begin
                dig_valid = 1'b1;
                dig_last  = 1'b1;
                dig_data  = pv ? p : '0;
            end
            default: begin
                dig_valid = 1'b0;
            end
        endcase
    end

    assign dig_hs = dig_valid && dig_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IN;
            carry     <= '0;
            p         <= '0;
            pv        <= 1'b0;
            n         <= '0;
            zrun      <= '0;
            ended     <= 1'b0;
            busy      <= 1'b0;
            dig_count <= '0;
        end else if (step_en) begin
            carry <= carry_nxt;
            if (state == S_IN) begin
                ended <= coef_last;
                busy  <= 1'b1;
                if (!busy)
                    dig_count <= '0;
            end
            // Zeros are only counted; they are emitted later if a
            // nonzero digit follows, otherwise dropped at S_FINAL.
            if (d_val == '0) begin
                zrun  <= zrun + ONE;
                state <= ret_state(ended_nxt, carry_nxt != '0);
            end else if (!pv && zrun == '0) begin
                p     <= d_val;
                pv    <= 1'b1;
                state <= ret_state(ended_nxt, carry_nxt != '0);
            end else begin
                n     <= d_val;
                state <= pv ? S_EMITP : S_ZERO;
            end
        end else if (dig_hs) begin
            dig_count <= dig_count + ONE;
            unique case (state)
                S_EMITP: begin
                    if (zrun != '0) begin
                        state <= S_ZERO;
                    end else begin
                        p     <= n;
                        state <= ret_state(ended, carry != '0);
                    end
                end
                S_ZERO: begin
                    zrun <= zrun - ONE;
                    if (zrun == ONE) begin
                        p     <= n;
                        pv    <= 1'b1;
                        state <= ret_state(ended, carry != '0);
                    end
                end
                S_FINAL: begin
                    carry <= '0;
                    zrun  <= '0;
                    pv    <= 1'b0;
                    ended <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IN;
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_carry_norm.sv
// tb_carry_norm: directed vectors for carry_norm (BASE=10) with a
// scoreboard queue filled by the driver and drained by a digit monitor.
module tb_carry_norm;

    logic        clk;
    logic        rst;
    logic        coef_valid;
    logic        coef_ready;
    logic [31:0] coef_data;
    logic        coef_last;
    logic        dig_valid;
    logic        dig_ready;
    logic [15:0] dig_data;
    logic        dig_last;
    logic [15:0] dig_count;
    logic        busy;

    carry_norm #(.WORD(16), .DWORD(32), .BASE(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_last  (coef_last),
        .dig_valid  (dig_valid),
        .dig_ready  (dig_ready),
        .dig_data   (dig_data),
        .dig_last   (dig_last),
        .dig_count  (dig_count),
        .busy       (busy)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t sb[$];
    int   cq[$];
    int   eq[$];

    int   checks = 0;
    int   errors = 0;
    bit   stall = 0;
    bit   in_tail = 0;
    int   last_cnt = 0;
    int   tail_base = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic put_c(input int a, input int b = -1,
                         input int c = -1, input int d = -1);
        cq.delete();
        cq.push_back(a);
        if (b >= 0) cq.push_back(b);
        if (c >= 0) cq.push_back(c);
        if (d >= 0) cq.push_back(d);
    endtask

    task automatic put_e(input int a, input int b = -1, input int c = -1,
                         input int d = -1, input int e = -1,
                         input int f = -1);
        eq.delete();
        eq.push_back(a);
        if (b >= 0) eq.push_back(b);
        if (c >= 0) eq.push_back(c);
        if (d >= 0) eq.push_back(d);
        if (e >= 0) eq.push_back(e);
        if (f >= 0) eq.push_back(f);
    endtask

    task automatic send(input int v, input bit last);
        int n;
        coef_valid = 1'b1;
        coef_data  = v;
        coef_last  = last;
        n = 0;
        @(negedge clk);
        while (!coef_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!coef_ready) begin
            chk("coef_accept_timeout", 0, 1);
        end else begin
            @(posedge clk);
            #1;
            if (last) begin
                tail_base = last_cnt;
                in_tail   = 1'b1;
            end
        end
        coef_valid = 1'b0;
        coef_last  = 1'b0;
        coef_data  = '0;
    endtask

    task automatic run(input bit st);
        int n;
        stall = st;
        for (int i = 0; i < eq.size(); i++)
            sb.push_back('{data: eq[i], last: (i == eq.size() - 1)});
        for (int i = 0; i < cq.size(); i++) begin
            send(cq[i], i == cq.size() - 1);
            if (i == 0) chk("busy_set", int'(busy), 1);
        end
        n = 0;
        while (last_cnt == tail_base && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("product_done", int'(last_cnt != tail_base), 1);
        chk("dig_count", int'(dig_count), eq.size());
        chk("busy_clear", int'(busy), 0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        in_tail = 1'b0;
        stall   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Ready generator: in stall mode each digit sees 3 low cycles first.
    initial begin
        bit v;
        bit r;
        int cnt;
        cnt = 0;
        dig_ready = 1'b1;
        forever begin
            @(negedge clk);
            v = dig_valid;
            r = dig_ready;
            @(posedge clk);
            #2;
            if (!stall) begin
                dig_ready = 1'b1;
                cnt = 0;
            end else begin
                if (v && r) cnt = 0;
                if (dig_valid) begin
                    if (cnt >= 3) begin
                        dig_ready = 1'b1;
                    end else begin
                        dig_ready = 1'b0;
                        cnt++;
                    end
                end else begin
                    dig_ready = 1'b0;
                end
            end
        end
    end

    // Monitor: compares handshaken digits, stall stability, tail ready.
    bit         held = 1'b0;
    logic [15:0] h_data;
    logic        h_last;
    exp_t        e_m;

    always @(negedge clk) begin
        if (!rst) begin
            if (in_tail && last_cnt == tail_base)
                chk("coef_ready_tail", int'(coef_ready), 0);
            if (held) begin
                chk("hold_valid", int'(dig_valid), 1);
                chk("hold_data", int'(dig_data), int'(h_data));
                chk("hold_last", int'(dig_last), int'(h_last));
            end
            if (dig_valid && dig_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_digit", int'(dig_data), -1);
                end else begin
                    e_m = sb.pop_front();
                    chk("dig_data", int'(dig_data), e_m.data);
                    chk("dig_last", int'(dig_last), int'(e_m.last));
                end
                if (dig_last) last_cnt++;
            end
            held   = dig_valid && !dig_ready;
            h_data = dig_data;
            h_last = dig_last;
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        int saved;
        rst        = 1'b1;
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_last  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_dig_valid", int'(dig_valid), 0);
        chk("rst_dig_last", int'(dig_last), 0);
        chk("rst_dig_data", int'(dig_data), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_coef_ready", int'(coef_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_dig_count", int'(dig_count), 0);
        @(posedge clk);
        #1;

        put_c(1, 2, 1);          put_e(1, 2, 1);             run(0);
        put_c(15, 27, 3, 0);     put_e(5, 8, 5);             run(0);
        put_c(0, 0, 0, 123);     put_e(0, 0, 0, 3, 2, 1);    run(0);
        put_c(0, 0, 0, 0);       put_e(0);                   run(0);
        put_c(1, 2, 1);          put_e(1, 2, 1);             run(1);
        put_c(5, 0, 0, 7);       put_e(5, 0, 0, 7);          run(0);
        put_c(99999);            put_e(9, 9, 9, 9, 9);       run(0);

        // Reset part-way through a product: nothing may come out.
        saved = last_cnt;
        send(3, 1'b0);
        send(0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_no_last", last_cnt, saved);
        chk("mid_rst_valid", int'(dig_valid), 0);
        chk("mid_rst_ready", int'(coef_ready), 1);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_count", int'(dig_count), 0);
        @(posedge clk);
        #1;
        put_c(0, 1, 1);          put_e(0, 1, 1);             run(0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
